mux4_rr_tx: RTL



---
 rtl/mux4_rr_tx_pkg.sv | 18 +
 rtl/mux4_rr_tx_rr_arb4.sv | 28 ++
 rtl/mux4_rr_tx.sv | 81 ++++++++
 3 files changed

// File: rtl/mux4_rr_tx_pkg.sv
// Shared constants for the 4-channel round-robin mux/demux link.
// Channel count, select width and pointer reset value live here.
package mux4_rr_tx_pkg;

  localparam int NCH  = 4;
  localparam int SELW = 2;

  localparam logic [SELW-1:0] LAST_RST = 2'd3;

  // Channel index k positions after p, modulo the channel count.
  function automatic logic [SELW-1:0] rr_step(
    input logic [SELW-1:0] p,
    input int              k
  );
    return SELW'(p + SELW'(k));
  endfunction

endpackage

// File: rtl/mux4_rr_tx_rr_arb4.sv
// Combinational 4-way round-robin arbiter.
// Search starts just after the last granted channel.
module rr_arb4
  import mux4_rr_tx_pkg::*;
(
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] last,
  input  logic            en,
  output logic [NCH-1:0]  gnt,
  output logic [SELW-1:0] gnt_idx,
  output logic            any
);

  // First requester in order last+1 .. last wins; gnt gated by en.
  always_comb begin
    any     = 1'b0;
    gnt_idx = last;
    gnt     = '0;
    for (int k = 1; k <= NCH; k++) begin
      if (!any && req[rr_step(last, k)]) begin
        any     = 1'b1;
        gnt_idx = rr_step(last, k);
      end
    end
    if (any && en) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/mux4_rr_tx.sv
// Merges four valid/ready channels onto one tagged output.
// Round-robin grant, single registered output stage.
module mux4_rr_tx
  import mux4_rr_tx_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    in_valid,
  input  logic [NCH*DATA_W-1:0] in_data,
  output logic [NCH-1:0]    in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [SELW-1:0]   out_sel,
  input  logic              out_ready
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [SELW-1:0]   r_sel;
  logic [SELW-1:0]   r_last;

  logic              w_load;
  logic              w_en;
  logic [NCH-1:0]    w_gnt;
  logic [SELW-1:0]   w_idx;
  logic              w_any;
  logic              w_fire;
  logic [DATA_W-1:0] w_word;

  assign w_load = ~r_valid | out_ready;
  assign w_en   = w_load & rst_n;
  assign w_fire = w_any & w_en;

  rr_arb4 u_arb (
    .req     (in_valid),
    .last    (r_last),
    .en      (w_en),
    .gnt     (w_gnt),
    .gnt_idx (w_idx),
    .any     (w_any)
  );

  // Select the granted channel's word for the output register.
  always_comb begin
    w_word = in_data[0 +: DATA_W];
    unique case (w_idx)
      2'd0: w_word = in_data[0*DATA_W +: DATA_W];
      2'd1: w_word = in_data[1*DATA_W +: DATA_W];
      2'd2: w_word = in_data[2*DATA_W +: DATA_W];
      2'd3: w_word = in_data[3*DATA_W +: DATA_W];
      default: w_word = in_data[0 +: DATA_W];
    endcase
  end

  // Output register and last-grant pointer; pop/push share one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= '0;
      r_last  <= LAST_RST;
    end else if (w_load) begin
      if (w_fire) begin
        r_valid <= 1'b1;
        r_data  <= w_word;
        r_sel   <= w_idx;
        r_last  <= w_idx;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = w_gnt;
  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_sel   = r_sel;

endmodule
